// File: rtl/traffic_phase_sequencer.sv
// Traffic phase sequencer: main/side road lamp controller driving an external interval Timer.
// Optional pedestrian WALK phase is compiled in when macro TLC_WALK_EN is defined.
module traffic_phase_sequencer #(
  parameter logic [3:0] BASE_TIME = 4'd12,
  parameter logic [3:0] EXT_TIME  = 4'd6,
  parameter logic [3:0] YEL_TIME  = 4'd3
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       expired,
  input  logic       Sensor,
  input  logic       Walk_Request,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] Light_Main,
  output logic [2:0] Light_Side,
  output logic       Walk
);

  typedef enum logic [2:0] {
    MG_BASE = 3'd0,
    MG_EXT  = 3'd1,
    M_YEL   = 3'd2,
    SG_BASE = 3'd3,
    SG_EXT  = 3'd4,
    S_YEL   = 3'd5
`ifdef TLC_WALK_EN
    , WALK  = 3'd6
`endif
  } state_e;

  state_e     state_q, state_d;
  logic       init_q;
  logic       start_q;
  logic       blank_q;
  logic       take_s;
  logic [3:0] value_q;
  logic [2:0] main_q;
  logic [2:0] side_q;

  function automatic logic [2:0] main_lamps(input state_e s);
    logic [2:0] r;
    case (s)
      MG_BASE, MG_EXT: r = 3'b001;
      M_YEL:           r = 3'b010;
      default:         r = 3'b100;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] side_lamps(input state_e s);
    logic [2:0] r;
    case (s)
      SG_BASE, SG_EXT: r = 3'b001;
      S_YEL:           r = 3'b010;
      default:         r = 3'b100;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] value_for(input state_e s);
    logic [3:0] r;
    case (s)
      MG_BASE, SG_BASE: r = BASE_TIME;
      M_YEL, S_YEL:     r = YEL_TIME;
      default:          r = EXT_TIME;
    endcase
    return r;
  endfunction

`ifdef TLC_WALK_EN
  logic wp_q;
  logic wp_d;
  logic walk_q;
`else
  logic unused_walk_request_s;
  assign unused_walk_request_s = Walk_Request;
`endif

  // Expiry is honoured only once the pulse and blanking cycles after an entry have passed.
  always_comb begin
    take_s  = 1'b0;
    state_d = state_q;
    if (!init_q && !start_q && !blank_q && expired) begin
      take_s = 1'b1;
      case (state_q)
        MG_BASE: state_d = Sensor ? M_YEL : MG_EXT;
        MG_EXT:  state_d = M_YEL;
`ifdef TLC_WALK_EN
        M_YEL:   state_d = wp_q ? WALK : SG_BASE;
        WALK:    state_d = SG_BASE;
`else
        M_YEL:   state_d = SG_BASE;
`endif
        SG_BASE: state_d = Sensor ? SG_EXT : S_YEL;
        SG_EXT:  state_d = S_YEL;
        S_YEL:   state_d = MG_BASE;
        default: state_d = MG_BASE;
      endcase
    end else begin
      take_s  = 1'b0;
      state_d = state_q;
    end
  end

`ifdef TLC_WALK_EN
  // A request arriving on the WALK-entry edge survives the clear and earns another WALK.
  always_comb begin
    wp_d = Walk_Request | (wp_q & ~(take_s & (state_d == WALK)));
  end
`endif

  // State, timing flags and lamp/interval outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MG_BASE;
      init_q  <= 1'b1;
      start_q <= 1'b0;
      blank_q <= 1'b0;
      value_q <= BASE_TIME;
      main_q  <= 3'b001;
      side_q  <= 3'b100;
`ifdef TLC_WALK_EN
      wp_q    <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= 1'b0;
      start_q <= init_q | take_s;
      blank_q <= start_q;
      value_q <= value_for(state_d);
      main_q  <= main_lamps(state_d);
      side_q  <= side_lamps(state_d);
`ifdef TLC_WALK_EN
      wp_q    <= wp_d;
      walk_q  <= (state_d == WALK);
`endif
    end
  end

  assign Value       = value_q;
  assign start_timer = start_q;
  assign Light_Main  = main_q;
  assign Light_Side  = side_q;
`ifdef TLC_WALK_EN
  assign Walk        = walk_q;
`else
  assign Walk        = 1'b0;
`endif

endmodule

// File: doc/traffic_phase_sequencer.md
TRAFFIC_PHASE_SEQUENCER -- requirements
Module: traffic_phase_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_TIME, default 4'd12, green base interval loaded into the Timer in seconds.
REQ-002 The block SHALL have parameter EXT_TIME, default 4'd6, green extension and walk interval in seconds.
REQ-003 The block SHALL have parameter YEL_TIME, default 4'd3, yellow interval in seconds; all three parameters SHALL be in the range 1..15.
REQ-004 clk  input  1  the single system clock; all state changes SHALL occur on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 expired  input  1  level from Timer, high when the loaded interval has elapsed.
REQ-007 Sensor  input  1  side-street vehicle present, synchronous to clk.
REQ-008 Walk_Request  input  1  pedestrian button, single-cycle or level, synchronous to clk.
REQ-009 Value  output  4  interval for Timer, registered.
REQ-010 start_timer  output  1  one-cycle pulse that loads Value into Timer.
REQ-011 Light_Main  output  3  main lamps {R,Y,G}: 100 red, 010 yellow, 001 green.
REQ-012 Light_Side  output  3  side lamps, same encoding as Light_Main.
REQ-013 Walk  output  1  pedestrian walk lamp.

Function
REQ-014 The block SHALL implement states MG_BASE, MG_EXT, M_YEL, WALK, SG_BASE, SG_EXT and S_YEL; outputs SHALL be registered and decoded from the next state.
REQ-015 Lamps per state SHALL be: MG_* main 001/side 100; M_YEL 010/100; SG_* 100/001; S_YEL 100/010; WALK 100/100 with Walk=1; Walk=0 in all other states.
REQ-016 On the edge that enters a state, Value SHALL take the state's interval: BASE_TIME for MG_BASE/SG_BASE, EXT_TIME for MG_EXT/SG_EXT/WALK, YEL_TIME for M_YEL/S_YEL.
REQ-017 start_timer SHALL be high for exactly the one cycle following each state entry and low otherwise.
REQ-018 expired SHALL be ignored while start_timer is high and for one further cycle (a 2-cycle blanking window).
REQ-019 After blanking, the first cycle with expired=1 SHALL cause a transition on that rising edge, with no additional latency.
REQ-020 MG_BASE expiry SHALL go to M_YEL if Sensor=1, else to MG_EXT; MG_EXT expiry SHALL go to M_YEL.
REQ-021 M_YEL expiry SHALL go to WALK if walk_pending=1, else to SG_BASE; WALK expiry SHALL go to SG_BASE.
REQ-022 SG_BASE expiry SHALL go to SG_EXT if Sensor=1, else to S_YEL; SG_EXT expiry SHALL go to S_YEL; S_YEL expiry SHALL go to MG_BASE.
REQ-023 Sensor SHALL be sampled only on the expiry edge and ignored at all other times.
REQ-024 walk_pending SHALL be set by Walk_Request=1 in any state and cleared on entry to WALK.
REQ-025 A Walk_Request coinciding with the WALK-entry edge SHALL leave walk_pending set, so a second WALK follows in the next cycle of phases.
REQ-026 Lamp outputs SHALL never show green or yellow on both roads simultaneously.

Reset
REQ-027 While Reset_n=0, the block SHALL hold: state MG_BASE, Light_Main=001, Light_Side=100, Walk=0, Value=BASE_TIME, start_timer=0, walk_pending=0.
REQ-028 On the first rising edge after Reset_n deasserts, start_timer SHALL assert for one cycle.
REQ-029 Reset asserted mid-phase SHALL take effect immediately, independent of clk.

Configuration
REQ-030 With macro TLC_WALK_EN defined, the WALK state, walk_pending and Walk_Request handling SHALL be compiled in as specified.
REQ-031 Without TLC_WALK_EN, the WALK state and walk_pending SHALL be absent, Walk SHALL be tied to 0, Walk_Request SHALL be ignored, and M_YEL expiry SHALL always go to SG_BASE.

Verification
REQ-032 Reset, then Sensor=0 with a Timer model -> Value sequence 12,6,3,12,3 and lamps MG,MG,M_YEL,SG,S_YEL repeating, one start_timer pulse per phase.
REQ-033 Sensor=1 held -> MG_EXT skipped and SG_EXT taken: Value sequence 12,3,12,6,3.
REQ-034 expired forced high continuously -> each state lasts exactly 3 cycles (pulse, blank, transition), with no double transitions.
REQ-035 TLC_WALK_EN defined, 1-cycle Walk_Request during SG_BASE -> after next M_YEL, WALK with lamps 100/100, Walk=1 and Value=6, then SG_BASE; no second WALK.
REQ-036 Reset_n pulsed low during SG_EXT -> outputs reach reset values asynchronously, and start_timer with Value=12 appears one edge after release.
